mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the Y86-64 datapath, directly downstream of the execute ALU (ALU_fun).
- Accepts one executed instruction at a time: icode, cnd, valE, valA, valP.
- Selects address and write data and runs a req/ack transaction with data memory.
- Presents valE, valM and a status code to writeback through a valid/ready handshake.
- Halts permanently on HLT, ADR or INS status until reset.

## Interface
Parameters:
- N, 64, datapath width
- MEM_BYTES, 8192, size of data memory in bytes; valid addresses satisfy addr + 8 <= MEM_BYTES
- TIMEOUT, 16, maximum cycles to wait for mem_ack (used only with the timeout feature)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; forces the reset state immediately
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept; 1 only in state IDLE
- icode  in  4  instruction code
- cnd  in  1  condition flag from execute; passed through unchanged
- valE  in  N  ALU result
- valA  in  N  register operand A
- valP  in  N  next PC
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  N  byte address
- mem_wdata  out  N  write data
- mem_ack  in  1  memory completes the request
- mem_err  in  1  qualifies mem_ack; sampled only when mem_ack = 1
- mem_rdata  in  N  read data; valid when mem_ack = 1
- out_valid  out  1  result available to writeback
- out_ready  in  1  writeback consumes the result
- out_icode  out  4  registered icode
- out_cnd  out  1  registered cnd
- out_valE  out  N  registered valE
- out_valM  out  N  read data; 0 for non-read instructions
- out_stat  out  3  status: AOK = 1, HLT = 2, ADR = 3, INS = 4

## Operation
Access selection by icode (all other legal icodes perform no access):
- 4 (rmmovq): write, addr = valE, data = valA
- A (pushq): write, addr = valE, data = valA
- 8 (call): write, addr = valE, data = valP
- 5 (mrmovq): read, addr = valE
- B (popq): read, addr = valA
- 9 (ret): read, addr = valA

Legal icodes: 0 to B. Status rules:
- icode > B: INS, no memory access.
- icode 0: HLT, no memory access.
- Access with addr > MEM_BYTES - 8 (unsigned compare, no wrap): ADR, mem_req is never raised.
- mem_ack with mem_err = 1: ADR, out_valM = 0.
- All other cases: AOK.

FSM states:
- IDLE: on in_valid, latch all inputs.
  - Legal in-range access: go to MEM.
  - Otherwise: go to DONE.
- MEM: mem_req = 1; mem_we, mem_addr and mem_wdata are held stable.
  - On mem_ack: capture mem_rdata (reads only) and go to DONE.
- DONE: out_valid = 1; outputs held stable.
  - On out_ready with out_stat = AOK: go to IDLE.
  - On out_ready with any other status: go to HALT.
- HALT: in_ready = 0, out_valid = 0, mem_req = 0. Left only by reset.

Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, out_valid 0, out_icode 0, out_cnd 0, out_valE 0, out_valM 0, out_stat 1 (AOK).

Reset during MEM drops mem_req asynchronously. The pending transaction is abandoned and a late mem_ack is ignored.

## Timing
- Instruction accepted at edge t.
  - No access: out_valid from t+1.
  - Access: mem_req from t+1.
- mem_ack sampled at edge k: mem_req deasserts and out_valid rises after edge k.
- Zero-wait memory (ack in the first request cycle): 2-cycle latency.
- Throughput: one instruction per (latency + 1) cycles minimum. IDLE is revisited between instructions.
- in_valid while in_ready = 0 is ignored. The upstream stage holds its data.
- mem_ack outside MEM is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter, cleared on entry to MEM, increments each MEM cycle without mem_ack.
  - Reaching TIMEOUT drops mem_req, sets stat ADR and moves to DONE.
  - mem_ack in the same cycle as expiry wins.
- MEM_TIMEOUT_EN undefined: no counter; MEM waits indefinitely.

## Structure
- Shared package y86_pkg holds:
  - icode constants (IHALT, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ)
  - stat codes (SAOK, SHLT, SADR, SINS)
  - the FSM state encoding
- One combinational sub-module, mem_addr_sel: inputs icode, valE, valA, valP; outputs access, we, addr, wdata, illegal.

## Test plan
- Legal write: rmmovq, valE = 0x100, valA = 0xDEADBEEF, ack 3 cycles after req.
  - Required: mem_we = 1, mem_addr = 0x100, mem_wdata = 0xDEADBEEF; out_stat = 1 one cycle after ack.
- Read from valA: popq, valA = 0x1F8, mem_rdata = 0x42, zero-wait ack.
  - Required: mem_addr = 0x1F8, out_valM = 0x42, out_valid 2 cycles after accept.
- Out-of-range address: mrmovq, valE = 8189 with MEM_BYTES = 8192.
  - Required: mem_req never rises; out_stat = 3; after out_ready, in_ready stays 0.
- Halt and illegal icode: icode 0 gives out_stat = 2 and HALT; after reset, icode 0xC gives out_stat = 4.
- Backpressure and reset:
  - out_ready = 0 for 5 cycles: outputs remain stable.
  - reset asserted mid-MEM: mem_req = 0 immediately; a later mem_ack produces no out_valid.
- With MEM_TIMEOUT_EN, TIMEOUT = 16, no ack:
  - Required: mem_req drops after 16 MEM cycles; out_stat = 3.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// memory-stage FSM state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_DONE = 2'd2,
        S_HALT = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_addr_sel.sv
// Decodes icode into the data-memory access: whether one happens, its
// direction, the byte address and the write data. Purely combinational.
module mem_addr_sel
    import y86_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic [3:0]   icode,
    input  logic [N-1:0] valE,
    input  logic [N-1:0] valA,
    input  logic [N-1:0] valP,
    output logic         access,
    output logic         we,
    output logic [N-1:0] addr,
    output logic [N-1:0] wdata,
    output logic         illegal
);

    // Access selection; icodes above popq are not part of the ISA.
    always_comb begin
        access  = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        illegal = (icode > IPOPQ);
        case (icode)
            IRMMOVQ, IPUSHQ: begin
                access = 1'b1;
                we     = 1'b1;
                addr   = valE;
                wdata  = valA;
            end
            ICALL: begin
                access = 1'b1;
                we     = 1'b1;
                addr   = valE;
                wdata  = valP;
            end
            IMRMOVQ: begin
                access = 1'b1;
                addr   = valE;
            end
            IPOPQ, IRET: begin
                access = 1'b1;
                addr   = valA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: latches one executed instruction, runs a req/ack
// transaction with data memory when needed, and hands valE/valM/stat to
// writeback over valid/ready. Stops in HALT on any non-AOK status.
// Optional feature: define MEM_TIMEOUT_EN to abort a memory request that is
// not acknowledged within TIMEOUT cycles (reported as ADR).
module mem_stage
    import y86_pkg::*;
#(
    parameter int unsigned N         = 64,
    parameter int unsigned MEM_BYTES = 8192,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   icode,
    input  logic         cnd,
    input  logic [N-1:0] valE,
    input  logic [N-1:0] valA,
    input  logic [N-1:0] valP,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic         mem_err,
    input  logic [N-1:0] mem_rdata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_icode,
    output logic         out_cnd,
    output logic [N-1:0] out_valE,
    output logic [N-1:0] out_valM,
    output logic [2:0]   out_stat
);

    // Highest legal start address of an 8-byte access.
    localparam logic [N-1:0] MAX_ADDR = N'(MEM_BYTES - 8);

    mem_state_t   state;
    logic         sel_access;
    logic         sel_we;
    logic [N-1:0] sel_addr;
    logic [N-1:0] sel_wdata;
    logic         sel_illegal;

    mem_addr_sel #(
        .N(N)
    ) u_sel (
        .icode   (icode),
        .valE    (valE),
        .valA    (valA),
        .valP    (valP),
        .access  (sel_access),
        .we      (sel_we),
        .addr    (sel_addr),
        .wdata   (sel_wdata),
        .illegal (sel_illegal)
    );

    assign in_ready = (state == S_IDLE);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    // Stage FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            out_valid <= 1'b0;
            out_icode <= 4'h0;
            out_cnd   <= 1'b0;
            out_valE  <= '0;
            out_valM  <= '0;
            out_stat  <= SAOK;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        out_icode <= icode;
                        out_cnd   <= cnd;
                        out_valE  <= valE;
                        out_valM  <= '0;
                        if (sel_illegal) begin
                            out_stat  <= SINS;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (icode == IHALT) begin
                            out_stat  <= SHLT;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (sel_access && (sel_addr > MAX_ADDR)) begin
                            out_stat  <= SADR;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (sel_access) begin
                            out_stat  <= SAOK;
                            mem_req   <= 1'b1;
                            mem_we    <= sel_we;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
`ifdef MEM_TIMEOUT_EN
                            wait_cnt  <= '0;
`endif
                            state     <= S_MEM;
                        end else begin
                            out_stat  <= SAOK;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MEM: begin
                    // An ack arriving on the expiry cycle still completes normally.
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                        if (mem_err) begin
                            out_stat <= SADR;
                            out_valM <= '0;
                        end else if (!mem_we) begin
                            out_valM <= mem_rdata;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        out_stat  <= SADR;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= (out_stat == SAOK) ? S_IDLE : S_HALT;
                    end
                end
                default: ;  // S_HALT: wait for reset
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a scoreboard of expected writeback
// results is filled when an instruction is driven and drained when the
// stage presents out_valid.
module tb_mem_stage;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   icode;
    logic         cnd;
    logic [N-1:0] valE, valA, valP;
    logic         mem_req, mem_we;
    logic [N-1:0] mem_addr, mem_wdata;
    logic         mem_ack, mem_err;
    logic [N-1:0] mem_rdata;
    logic         out_valid, out_ready;
    logic [3:0]   out_icode;
    logic         out_cnd;
    logic [N-1:0] out_valE, out_valM;
    logic [2:0]   out_stat;

    typedef struct {
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [2:0]  stat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_stage #(
        .N         (N),
        .MEM_BYTES (8192),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .cnd       (cnd),
        .valE      (valE),
        .valA      (valA),
        .valP      (valP),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_err   (mem_err),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_icode (out_icode),
        .out_cnd   (out_cnd),
        .out_valE  (out_valE),
        .out_valM  (out_valM),
        .out_stat  (out_stat)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Drive one instruction, act as the memory, and check the result.
    task automatic run_instr(input string name, input logic [3:0] ic, input logic c,
                             input logic [63:0] e, input logic [63:0] a, input logic [63:0] p,
                             input int delay, input logic [63:0] rd, input logic err,
                             input logic acc, input logic we, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [63:0] exp_valm,
                             input logic [2:0] exp_stat);
        exp_t x;
        exp_t y;
        int   n;
        x = '{ic, c, e, exp_valm, exp_stat};
        sb.push_back(x);
        check({name, ":in_ready"}, in_ready, 1);
        icode = ic; cnd = c; valE = e; valA = a; valP = p; in_valid = 1'b1;
        tick();
        // Upstream moves on; the stage must have latched everything.
        in_valid = 1'b0; icode = 4'h1; cnd = ~c; valE = ~e; valA = ~a; valP = ~p;
        if (acc) begin
            check({name, ":req"}, mem_req, 1);
            check({name, ":we"}, mem_we, we);
            check({name, ":addr"}, mem_addr, addr);
            if (we) check({name, ":wdata"}, mem_wdata, wd);
            check({name, ":early_valid"}, out_valid, 0);
            for (int i = 0; i < delay; i++) begin
                tick();
                check({name, ":req_hold"}, mem_req, 1);
                check({name, ":addr_hold"}, mem_addr, addr);
            end
            mem_ack = 1'b1; mem_rdata = rd; mem_err = err;
            tick();
            mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            check({name, ":req_drop"}, mem_req, 0);
        end else begin
            check({name, ":no_req"}, mem_req, 0);
        end
        check({name, ":valid_latency"}, out_valid, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            check({name, ":valid_timeout"}, out_valid, 1);
        end else if (sb.size() > 0) begin
            y = sb.pop_front();
            check({name, ":icode"}, out_icode, y.icode);
            check({name, ":cnd"}, out_cnd, y.cnd);
            check({name, ":valE"}, out_valE, y.vale);
            check({name, ":valM"}, out_valM, y.valm);
            check({name, ":stat"}, out_stat, y.stat);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, ":valid_clear"}, out_valid, 0);
        check({name, ":ready_after"}, in_ready, exp_stat == 3'd1);
        if (exp_stat != 3'd1) begin
            // Halted: fresh input must not wake the stage.
            in_valid = 1'b1; icode = 4'h4; valE = 64'h10;
            repeat (3) tick();
            in_valid = 1'b0;
            check({name, ":halt_ready"}, in_ready, 0);
            check({name, ":halt_req"}, mem_req, 0);
            check({name, ":halt_valid"}, out_valid, 0);
        end
    endtask

    initial begin
        logic [63:0] held_vale;
        in_valid = 0; icode = 0; cnd = 0; valE = 0; valA = 0; valP = 0;
        mem_ack = 0; mem_err = 0; mem_rdata = 0; out_ready = 0;
        do_reset();

        check("rst:in_ready", in_ready, 1);
        check("rst:out_valid", out_valid, 0);
        check("rst:mem_req", mem_req, 0);
        check("rst:mem_addr", mem_addr, 0);
        check("rst:out_valM", out_valM, 0);
        check("rst:out_stat", out_stat, 1);

        // Writes: rmmovq, pushq, call (call stores valP).
        run_instr("rmmovq", 4'h4, 1'b0, 64'h100, 64'hDEADBEEF, 64'h0, 3, 64'h0, 1'b0,
                  1'b1, 1'b1, 64'h100, 64'hDEADBEEF, 64'h0, 3'd1);
        run_instr("pushq", 4'hA, 1'b1, 64'h1000, 64'h55AA, 64'h7, 1, 64'h0, 1'b0,
                  1'b1, 1'b1, 64'h1000, 64'h55AA, 64'h0, 3'd1);
        run_instr("call", 4'h8, 1'b0, 64'h3F0, 64'h9, 64'h55, 0, 64'h0, 1'b0,
                  1'b1, 1'b1, 64'h3F0, 64'h55, 64'h0, 3'd1);
        // Reads: popq/ret address from valA, mrmovq from valE.
        run_instr("popq", 4'hB, 1'b0, 64'h200, 64'h1F8, 64'h0, 0, 64'h42, 1'b0,
                  1'b1, 1'b0, 64'h1F8, 64'h0, 64'h42, 3'd1);
        run_instr("ret", 4'h9, 1'b1, 64'h18, 64'h10, 64'h0, 2, 64'h77, 1'b0,
                  1'b1, 1'b0, 64'h10, 64'h0, 64'h77, 3'd1);
        run_instr("mrmovq_max", 4'h5, 1'b0, 64'd8184, 64'h0, 64'h0, 1, 64'h5, 1'b0,
                  1'b1, 1'b0, 64'd8184, 64'h0, 64'h5, 3'd1);
        run_instr("opq", 4'h6, 1'b1, 64'hABCD, 64'h1, 64'h2, 0, 64'h0, 1'b0,
                  1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 3'd1);

        // Backpressure: result held for 5 cycles while writeback stalls.
        icode = 4'h2; cnd = 1'b1; valE = 64'h1234_5678; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; valE = 64'h0;
        held_vale = 64'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            mem_ack = (i == 2);  // stray ack outside MEM
            tick();
            check("bp:valid", out_valid, 1);
            check("bp:valE", out_valE, held_vale);
            check("bp:stat", out_stat, 1);
            check("bp:in_ready", in_ready, 0);
        end
        mem_ack = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp:idle", in_ready, 1);

        // Memory error on read: ADR with valM forced to 0, then halt.
        run_instr("mem_err", 4'h5, 1'b0, 64'h40, 64'h0, 64'h0, 0, 64'h99, 1'b1,
                  1'b1, 1'b0, 64'h40, 64'h0, 64'h0, 3'd3);
        do_reset();
        // Out-of-range: 8189 > 8192 - 8, no request.
        run_instr("oor", 4'h5, 1'b0, 64'd8189, 64'h0, 64'h0, 0, 64'h0, 1'b0,
                  1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 3'd3);
        do_reset();
        run_instr("halt", 4'h0, 1'b0, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1'b0,
                  1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 3'd2);
        do_reset();
        run_instr("ins", 4'hC, 1'b0, 64'h8, 64'h0, 64'h0, 0, 64'h0, 1'b0,
                  1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 3'd4);
        do_reset();

        // Reset in the middle of a memory transaction.
        icode = 4'h4; valE = 64'h300; valA = 64'h1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rstmem:req", mem_req, 1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("rstmem:req_async", mem_req, 0);
        tick();
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 64'h66;
        tick();
        mem_ack = 1'b0;
        check("rstmem:no_valid", out_valid, 0);
        tick();
        check("rstmem:no_valid2", out_valid, 0);
        check("rstmem:in_ready", in_ready, 1);
        check("rstmem:no_req", mem_req, 0);

`ifdef MEM_TIMEOUT_EN
        begin
            int n;
            icode = 4'h5; valE = 64'h80; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n = 0;
            while (mem_req && n < 40) begin
                n++;
                tick();
            end
            check("tmo:req_cycles", n, 16);
            check("tmo:valid", out_valid, 1);
            check("tmo:stat", out_stat, 3);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("tmo:halt", in_ready, 0);
        end
`endif

        check("sb:empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
